// File: rtl/pktgen_pkg.sv
// pktgen_pkg: shared state encoding and lane geometry for the AXIS packet generator.
package pktgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } pktgen_state_e;

  localparam int LANE_W = 64;

  function automatic int num_lanes(input int data_w);
    return data_w / LANE_W;
  endfunction

  function automatic int lane_lsb(input int lane);
    return lane * LANE_W;
  endfunction

endpackage

// File: rtl/pktgen_payload.sv
// pktgen_payload: packs counter, packet number and beat index into 64-bit lanes
// of the beat payload, with inverted copies in the top lanes.
module pktgen_payload
  import pktgen_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int BEAT_W  = 16,
  parameter int COUNT_W = 64
) (
  input  logic [COUNT_W-1:0] counter,
  input  logic [COUNT_W-1:0] packet_num,
  input  logic [BEAT_W-1:0]  beat_idx,
  output logic [DATA_W-1:0]  tdata
);

  localparam int N      = num_lanes(DATA_W);
  localparam int L_CNT  = lane_lsb(0);
  localparam int L_PKT  = lane_lsb(1);
  localparam int L_IDX  = lane_lsb(2);
  localparam int L_NPKT = lane_lsb(N - 2);
  localparam int L_NCNT = lane_lsb(N - 1);

  logic [LANE_W-1:0] cnt_lane;
  logic [LANE_W-1:0] pkt_lane;
  logic [LANE_W-1:0] idx_lane;

  always_comb begin
    cnt_lane = LANE_W'(counter);
    pkt_lane = LANE_W'(packet_num);
    idx_lane = LANE_W'(beat_idx);
    tdata    = '0;
    tdata[L_CNT +: LANE_W] = cnt_lane;
    tdata[L_PKT +: LANE_W] = pkt_lane;
    // With only four lanes, lane 2 is the inverted packet number, so no beat index.
    if (N >= 5) tdata[L_IDX +: LANE_W] = idx_lane;
    tdata[L_NPKT +: LANE_W] = ~pkt_lane;
    tdata[L_NCNT +: LANE_W] = ~cnt_lane;
  end

endmodule

// File: rtl/packet_generator.sv
// packet_generator: AXI4-Stream test-packet source with runtime packet length/count,
// continuous mode and graceful stop. Define PKTGEN_GAP_EN for idle gaps between packets.
module packet_generator
  import pktgen_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int BEAT_W  = 16,
  parameter int COUNT_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] packet_count,
  input  logic [BEAT_W-1:0]  beats_per_packet,
  input  logic [15:0]        gap_cycles,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] packets_sent,
  output logic [DATA_W-1:0]  AXIS_TX_TDATA,
  output logic               AXIS_TX_TVALID,
  output logic               AXIS_TX_TLAST,
  input  logic               AXIS_TX_TREADY,
  output pktgen_state_e      dbg_state
);

  pktgen_state_e      state_q, state_d;
  logic [COUNT_W-1:0] counter_q, counter_d;
  logic [COUNT_W-1:0] packet_num_q, packet_num_d;
  logic [COUNT_W-1:0] packets_sent_q, packets_sent_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] lat_count_q, lat_count_d;
  logic [BEAT_W-1:0]  beat_idx_q, beat_idx_d;
  logic [BEAT_W-1:0]  lat_beats_q, lat_beats_d;
  logic [BEAT_W-1:0]  run_beats_q, run_beats_d;
  logic               run_cont_q, run_cont_d;
  logic               pending_start_q, pending_start_d;
  logic               pending_stop_q, pending_stop_d;
  logic               done_q, done_d;
  logic               launch, last_beat, hs, pkt_done, end_req, end_run, to_idle;
`ifdef PKTGEN_GAP_EN
  logic [15:0]        lat_gap_q, lat_gap_d;
  logic [15:0]        run_gap_q, run_gap_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
`else
  logic               unused_gap;
  assign unused_gap = ^gap_cycles;
`endif

  // AXIS handshake: a beat transfers on a clk edge where TVALID and TREADY are both
  // high; TVALID is high exactly in SEND and TDATA/TLAST only move on a transfer.
  always_comb begin
    launch    = (state_q == S_IDLE) && pending_start_q;
    last_beat = (beat_idx_q == run_beats_q - BEAT_W'(1));
    hs        = (state_q == S_SEND) && AXIS_TX_TREADY;
    pkt_done  = hs && last_beat;
    end_req   = pending_start_q || pending_stop_q;
    end_run   = end_req || (!run_cont_q && (remaining_q == COUNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pending_start_q) state_d = S_SEND;
      S_SEND: begin
        if (pkt_done) begin
          if (end_run) state_d = S_IDLE;
`ifdef PKTGEN_GAP_EN
          else if (run_gap_q != '0) state_d = S_GAP;
`endif
        end
      end
`ifdef PKTGEN_GAP_EN
      S_GAP: begin
        if (end_req) state_d = S_IDLE;
        else if (gap_cnt_q == 16'd1) state_d = S_SEND;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    counter_d      = counter_q;
    packet_num_d   = packet_num_q;
    packets_sent_d = packets_sent_q;
    remaining_d    = remaining_q;
    beat_idx_d     = beat_idx_q;
    run_beats_d    = run_beats_q;
    run_cont_d     = run_cont_q;
    lat_count_d    = start ? packet_count : lat_count_q;
    lat_beats_d    = start ? beats_per_packet : lat_beats_q;
    to_idle        = (state_q != S_IDLE) && (state_d == S_IDLE);
    done_d         = to_idle;
    if (launch) begin
      counter_d      = '0;
      packet_num_d   = '0;
      packets_sent_d = '0;
      beat_idx_d     = '0;
      remaining_d    = lat_count_q;
      run_beats_d    = (lat_beats_q == '0) ? BEAT_W'(1) : lat_beats_q;
      run_cont_d     = (lat_count_q == '0);
    end else if (hs) begin
      counter_d  = counter_q + COUNT_W'(1);
      beat_idx_d = last_beat ? '0 : beat_idx_q + BEAT_W'(1);
      if (last_beat) begin
        packet_num_d   = packet_num_q + COUNT_W'(1);
        packets_sent_d = packets_sent_q + COUNT_W'(1);
        if (!run_cont_q) remaining_d = remaining_q - COUNT_W'(1);
      end
    end
    // A start that coincides with a stop wins; the stop is dropped.
    pending_start_d = start ? 1'b1 : (launch ? 1'b0 : pending_start_q);
    pending_stop_d  = (launch || to_idle) ? 1'b0 : pending_stop_q;
    if (stop && !start) pending_stop_d = 1'b1;
`ifdef PKTGEN_GAP_EN
    lat_gap_d = start ? gap_cycles : lat_gap_q;
    run_gap_d = launch ? lat_gap_q : run_gap_q;
    gap_cnt_d = gap_cnt_q;
    if ((state_q == S_SEND) && (state_d == S_GAP)) gap_cnt_d = run_gap_q;
    else if (state_q == S_GAP) gap_cnt_d = gap_cnt_q - 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q       <= '0;
      packet_num_q    <= '0;
      packets_sent_q  <= '0;
      remaining_q     <= '0;
      lat_count_q     <= '0;
      beat_idx_q      <= '0;
      lat_beats_q     <= '0;
      run_beats_q     <= BEAT_W'(1);
      run_cont_q      <= 1'b0;
      pending_start_q <= 1'b0;
      pending_stop_q  <= 1'b0;
      done_q          <= 1'b0;
`ifdef PKTGEN_GAP_EN
      lat_gap_q       <= '0;
      run_gap_q       <= '0;
      gap_cnt_q       <= '0;
`endif
    end else begin
      counter_q       <= counter_d;
      packet_num_q    <= packet_num_d;
      packets_sent_q  <= packets_sent_d;
      remaining_q     <= remaining_d;
      lat_count_q     <= lat_count_d;
      beat_idx_q      <= beat_idx_d;
      lat_beats_q     <= lat_beats_d;
      run_beats_q     <= run_beats_d;
      run_cont_q      <= run_cont_d;
      pending_start_q <= pending_start_d;
      pending_stop_q  <= pending_stop_d;
      done_q          <= done_d;
`ifdef PKTGEN_GAP_EN
      lat_gap_q       <= lat_gap_d;
      run_gap_q       <= run_gap_d;
      gap_cnt_q       <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = done_q;
    packets_sent   = packets_sent_q;
    AXIS_TX_TVALID = (state_q == S_SEND);
    AXIS_TX_TLAST  = last_beat;
    dbg_state      = state_q;
  end

  pktgen_payload #(
    .DATA_W (DATA_W),
    .BEAT_W (BEAT_W),
    .COUNT_W(COUNT_W)
  ) u_payload (
    .counter   (counter_q),
    .packet_num(packet_num_q),
    .beat_idx  (beat_idx_q),
    .tdata     (AXIS_TX_TDATA)
  );

endmodule

// File: tb/tb_packet_generator.sv
// tb_packet_generator: table-driven runs plus hand-written stop/restart/gap/reset
// sequences, all beats scored against a queue built from the packet rules.
module tb_packet_generator;
  import pktgen_pkg::*;

  localparam int DATA_W  = 512;
  localparam int BEAT_W  = 16;
  localparam int COUNT_W = 64;
  localparam int NL      = DATA_W / 64;
`ifdef PKTGEN_GAP_EN
  localparam int GAP_EXP = 4;
`else
  localparam int GAP_EXP = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [COUNT_W-1:0] packet_count;
  logic [BEAT_W-1:0]  beats_per_packet;
  logic [15:0]        gap_cycles;
  logic               start, stop;
  logic               busy, done;
  logic [COUNT_W-1:0] packets_sent;
  logic [DATA_W-1:0]  AXIS_TX_TDATA;
  logic               AXIS_TX_TVALID, AXIS_TX_TLAST, AXIS_TX_TREADY;
  pktgen_state_e      dbg_state;

  packet_generator #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset), .packet_count(packet_count),
    .beats_per_packet(beats_per_packet), .gap_cycles(gap_cycles),
    .start(start), .stop(stop), .busy(busy), .done(done), .packets_sent(packets_sent),
    .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TVALID(AXIS_TX_TVALID),
    .AXIS_TX_TLAST(AXIS_TX_TLAST), .AXIS_TX_TREADY(AXIS_TX_TREADY), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DATA_W:0] exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     beats_seen = 0;
  int     done_cnt = 0;
  int     idle_sum = 0;
  longint last_hs = 0;
  bit     first_hs = 1'b1;
  bit     rand_rdy = 1'b0;
  bit     stall_prev = 1'b0;
  bit     done_prev = 1'b0;
  logic [DATA_W:0] prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference beat: {tlast, payload} from the packet rules
  function automatic logic [DATA_W:0] exp_beat(input longint unsigned cnt, input longint unsigned pn,
                                                input longint unsigned bi, input bit last);
    logic [DATA_W-1:0] d;
    d = '0;
    d[0 +: 64]  = cnt;
    d[64 +: 64] = pn;
    if (NL >= 5) d[128 +: 64] = bi;
    d[(NL-2)*64 +: 64] = ~pn;
    d[(NL-1)*64 +: 64] = ~cnt;
    return {last, d};
  endfunction

  task automatic queue_run(input longint unsigned pkts, input int unsigned beats);
    int unsigned b_eff;
    b_eff = (beats == 0) ? 1 : beats;
    for (longint unsigned p = 0; p < pkts; p++)
      for (int unsigned b = 0; b < b_eff; b++)
        exp_q.push_back(exp_beat(p * b_eff + b, p, b, b == b_eff - 1));
  endtask

  // driver tasks
  initial begin
    AXIS_TX_TREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      AXIS_TX_TREADY = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic pulse_start(input longint unsigned cnt, input int unsigned beats,
                             input int unsigned gap, input bit with_stop);
    @(posedge clk); #1;
    packet_count     = cnt;
    beats_per_packet = BEAT_W'(beats);
    gap_cycles       = 16'(gap);
    start            = 1'b1;
    stop             = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(beats_seen >= target), 64'd1);
  endtask

  task automatic new_seq();
    exp_q.delete();
    beats_seen = 0;
    idle_sum   = 0;
    first_hs   = 1'b1;
  endtask

  // monitor: transfer happens at the next posedge when valid & ready at this negedge
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(AXIS_TX_TVALID), 64'd1);
        check_wide("stall_beat", {AXIS_TX_TLAST, AXIS_TX_TDATA}, prev_beat);
      end
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra: got beat lane0=%0h expected no beat", AXIS_TX_TDATA[63:0]);
        end else begin
          check_wide("beat", {AXIS_TX_TLAST, AXIS_TX_TDATA}, exp_q.pop_front());
        end
        if (!first_hs) idle_sum += int'(cyc - last_hs - 1);
        first_hs = 1'b0;
        last_hs  = cyc;
      end
      stall_prev = AXIS_TX_TVALID && !AXIS_TX_TREADY;
      prev_beat  = {AXIS_TX_TLAST, AXIS_TX_TDATA};
      if (done) begin
        done_cnt++;
        check("done_pulse", 64'(done_prev), 64'd0);
      end
      done_prev = done;
    end
  end

  typedef struct {
    longint unsigned count;
    int unsigned     beats;
    bit              rnd;
    longint unsigned exp_sent;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int d0;
    longint unsigned c;
    int unsigned b;

    tbl[0] = '{2, 16, 1'b0, 2};
    tbl[1] = '{2, 3, 1'b1, 2};
    tbl[2] = '{3, 0, 1'b1, 3};
    tbl[3] = '{1, 1, 1'b0, 1};
    tbl[4] = '{4, 5, 1'b1, 4};
    for (int i = 5; i < 8; i++) begin
      c = $urandom_range(1, 4);
      b = $urandom_range(0, 6);
      tbl[i] = '{c, b, 1'b1, c};
    end

    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    packet_count = '0;
    beats_per_packet = '0;
    gap_cycles = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 64'(AXIS_TX_TVALID), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sent", packets_sent, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));

    for (int i = 0; i < 8; i++) begin
      new_seq();
      rand_rdy = tbl[i].rnd;
      queue_run(tbl[i].count, tbl[i].beats);
      d0 = done_cnt;
      pulse_start(tbl[i].count, tbl[i].beats, 0, 1'b0);
      wait_done(d0 + 1, 2000, "tbl_done");
      repeat (3) @(negedge clk);
      check("tbl_sent", packets_sent, tbl[i].exp_sent);
      check("tbl_drain", 64'(exp_q.size()), 64'd0);
      check("tbl_busy", 64'(busy), 64'd0);
      check("tbl_done_cnt", 64'(done_cnt - d0), 64'd1);
      if (!tbl[i].rnd) check("tbl_idle", 64'(idle_sum), 64'd0);
    end

    // continuous run, stop during packet 2
    new_seq();
    rand_rdy = 1'b0;
    queue_run(3, 16);
    d0 = done_cnt;
    pulse_start(0, 16, 0, 1'b0);
    wait_beats(40, 500, "cont_beats");
    pulse_stop();
    wait_done(d0 + 1, 500, "cont_done");
    repeat (3) @(negedge clk);
    check("cont_sent", packets_sent, 64'd3);
    check("cont_total", 64'(beats_seen), 64'd48);
    check("cont_drain", 64'(exp_q.size()), 64'd0);

    // restart in the middle of packet 1 of 5
    new_seq();
    queue_run(2, 4);
    queue_run(5, 4);
    d0 = done_cnt;
    pulse_start(5, 4, 0, 1'b0);
    wait_beats(5, 200, "rst_beats");
    pulse_start(5, 4, 0, 1'b0);
    wait_done(d0 + 2, 500, "restart_done");
    repeat (3) @(negedge clk);
    check("restart_sent", packets_sent, 64'd5);
    check("restart_idle", 64'(idle_sum), 64'd1);
    check("restart_drain", 64'(exp_q.size()), 64'd0);
    check("restart_done_cnt", 64'(done_cnt - d0), 64'd2);

    // start and stop together from IDLE: the run launches and is not cut short
    new_seq();
    queue_run(2, 2);
    d0 = done_cnt;
    pulse_start(2, 2, 0, 1'b1);
    wait_done(d0 + 1, 200, "ss_done");
    repeat (3) @(negedge clk);
    check("ss_sent", packets_sent, 64'd2);
    check("ss_drain", 64'(exp_q.size()), 64'd0);

    // inter-packet gap of 4 requested
    new_seq();
    queue_run(3, 2);
    d0 = done_cnt;
    pulse_start(3, 2, 4, 1'b0);
    wait_done(d0 + 1, 300, "gap_done");
    repeat (3) @(negedge clk);
    check("gap_idle", 64'(idle_sum), 64'(2 * GAP_EXP));
    check("gap_sent", packets_sent, 64'd3);
    check("gap_drain", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a continuous run
    new_seq();
    queue_run(1, 16);
    pulse_start(0, 16, 0, 1'b0);
    wait_beats(6, 200, "mid_beats");
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_tvalid", 64'(AXIS_TX_TVALID), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_sent", packets_sent, 64'd0);
    #1 reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("mid_idle", 64'(AXIS_TX_TVALID), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
